// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared time-field layout, field limits and FSM state encoding for the
// lap timer.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package timer_pkg;

   // Packed time word: hour[23:19] min[18:13] sec[12:7] tick[6:0]
   localparam int TIME_W   = 24;
   localparam int TICK_W   = 7;
   localparam int SEC_W    = 6;
   localparam int MIN_W    = 6;
   localparam int HOUR_W   = 5;

   localparam int TICK_LSB = 0;
   localparam int SEC_LSB  = 7;
   localparam int MIN_LSB  = 13;
   localparam int HOUR_LSB = 19;

   localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
   localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
   localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_STOP    = 2'd2,
      ST_EXPIRED = 2'd3
   } state_e;

   // Field order matches the bit positions above (MSB first)
   typedef struct packed {
      logic [HOUR_W-1:0] hour;
      logic [MIN_W-1:0]  minute;
      logic [SEC_W-1:0]  second;
      logic [TICK_W-1:0] tick;
   } time_t;

endpackage

`default_nettype wire

// File: rtl/time_counter.sv
// ---------------------------------------------------------------------------
// time_counter
// Tick prescaler plus cascaded tick/sec/min/hour counter. Countdown with
// saturating preset load is compiled in only with LAP_TIMER_COUNTDOWN_EN.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module time_counter
   import timer_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int TICK_HZ     = 100
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clear,
   input  logic              i_run,
   input  logic              i_load,
   input  logic              i_down,
   input  logic [TIME_W-1:0] i_preset,
   output logic [TIME_W-1:0] o_time,
   output logic              o_zero
);

   localparam int DIV = ((CLK_FREQ_HZ / TICK_HZ) > 0) ? (CLK_FREQ_HZ / TICK_HZ) : 1;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_HZ - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   time_t            time_q, time_d, up_time;
   logic             tick;

   // Terminal count of the prescaler is the tick; clear suppresses it
   assign tick = i_run && !i_clear && (pre_q == PRE_LAST);

   // Prescaler advances only while running, parked at zero otherwise
   always_comb begin
      pre_d = pre_q + 1'b1;
      if (i_clear || !i_run || tick) begin
         pre_d = '0;
      end
   end

   // Up-count by one tick with carry into sec/min/hour, full-day wrap
   always_comb begin
      up_time = time_q;
      if (time_q.tick == TICK_LAST) begin
         up_time.tick = '0;
         if (time_q.second == SEC_MAX) begin
            up_time.second = '0;
            if (time_q.minute == MIN_MAX) begin
               up_time.minute = '0;
               if (time_q.hour == HOUR_MAX) begin
                  up_time.hour = '0;
               end else begin
                  up_time.hour = time_q.hour + 1'b1;
               end
            end else begin
               up_time.minute = time_q.minute + 1'b1;
            end
         end else begin
            up_time.second = time_q.second + 1'b1;
         end
      end else begin
         up_time.tick = time_q.tick + 1'b1;
      end
   end

`ifdef LAP_TIMER_COUNTDOWN_EN
   time_t preset_val, load_time, dn_time;

   assign preset_val = time_t'(i_preset);

   // Preset load with each out-of-range field clamped to its maximum
   always_comb begin
      load_time = preset_val;
      if (preset_val.tick > TICK_LAST) load_time.tick = TICK_LAST;
      if (preset_val.second > SEC_MAX) load_time.second = SEC_MAX;
      if (preset_val.minute > MIN_MAX) load_time.minute = MIN_MAX;
      if (preset_val.hour > HOUR_MAX) load_time.hour = HOUR_MAX;
   end

   // Down-count by one tick with borrow; an all-zero time stays at zero
   always_comb begin
      dn_time = time_q;
      if (time_q.tick != '0) begin
         dn_time.tick = time_q.tick - 1'b1;
      end else begin
         dn_time.tick = TICK_LAST;
         if (time_q.second != '0) begin
            dn_time.second = time_q.second - 1'b1;
         end else begin
            dn_time.second = SEC_MAX;
            if (time_q.minute != '0) begin
               dn_time.minute = time_q.minute - 1'b1;
            end else begin
               dn_time.minute = MIN_MAX;
               dn_time.hour   = time_q.hour - 1'b1;
            end
         end
      end
      if (time_q == '0) begin
         dn_time = '0;
      end
   end

   assign o_zero = tick && i_down && (dn_time == '0);

   // Time register next value: clear, then load, then tick update
   always_comb begin
      time_d = time_q;
      if (i_clear) begin
         time_d = '0;
      end else if (i_load) begin
         time_d = load_time;
      end else if (tick) begin
         time_d = i_down ? dn_time : up_time;
      end
   end
`else
   // Countdown controls have no effect in this build
   logic unused_cfg;
   assign unused_cfg = ^{i_load, i_down, i_preset};
   assign o_zero     = 1'b0;

   // Time register next value: clear, then tick update
   always_comb begin
      time_d = time_q;
      if (i_clear) begin
         time_d = '0;
      end else if (tick) begin
         time_d = up_time;
      end
   end
`endif

   // Prescaler and time registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q  <= '0;
         time_q <= '0;
      end else begin
         pre_q  <= pre_d;
         time_q <= time_d;
      end
   end

   assign o_time = time_q;

endmodule

`default_nettype wire

// File: rtl/lap_timer.sv
// ---------------------------------------------------------------------------
// lap_timer
// Run/stop stopwatch with a circular lap-capture buffer. Countdown mode,
// preset load and expiry are compiled in only with LAP_TIMER_COUNTDOWN_EN.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module lap_timer
   import timer_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int TICK_HZ     = 100,
   parameter int LAP_DEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_runstop,
   input  logic                       i_clear,
   input  logic                       i_lap,
   input  logic                       i_lap_rd,
   input  logic                       i_mode_down,
   input  logic                       i_load,
   input  logic [TIME_W-1:0]          i_preset,
   output logic [TIME_W-1:0]          o_time,
   output logic [TIME_W-1:0]          o_lap_data,
   output logic                       o_lap_valid,
   output logic [$clog2(LAP_DEPTH):0] o_lap_count,
   output logic                       o_lap_ovf,
   output logic                       o_running,
   output logic                       o_expired
);

   localparam int PTR_W = $clog2(LAP_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LAP_DEPTH);

   state_e            state_q, state_d;
   logic              zero;
   logic              load_en;

   logic [TIME_W-1:0] lap_mem_q [LAP_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [TIME_W-1:0] lap_data_q, lap_data_d;
   logic              lap_valid_q, lap_valid_d;
   logic              ovf_q, ovf_d;
   logic              full, lap_wr, lap_rd;

   assign load_en = i_load && ((state_q == ST_IDLE) || (state_q == ST_STOP));

   time_counter #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .TICK_HZ     (TICK_HZ)
   ) u_time_counter (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (i_clear),
      .i_run    (state_q == ST_RUN),
      .i_load   (load_en),
      .i_down   (i_mode_down),
      .i_preset (i_preset),
      .o_time   (o_time),
      .o_zero   (zero)
   );

   // Run-state next-state logic; clear wins, expiry beats a stop request
   always_comb begin
      state_d = state_q;
      if (i_clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    if (i_runstop) state_d = ST_RUN;
            ST_RUN: begin
               if (zero)           state_d = ST_EXPIRED;
               else if (i_runstop) state_d = ST_STOP;
            end
            ST_STOP:    if (i_runstop) state_d = ST_RUN;
            ST_EXPIRED: state_d = ST_EXPIRED;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   // Run-state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   assign o_running = (state_q == ST_RUN);
`ifdef LAP_TIMER_COUNTDOWN_EN
   assign o_expired = (state_q == ST_EXPIRED);
`else
   assign o_expired = 1'b0;
`endif

   assign full   = (count_q == CNT_FULL);
   assign lap_wr = i_lap && !i_clear && ((state_q == ST_RUN) || (state_q == ST_STOP));
   assign lap_rd = i_lap_rd && !i_clear && (count_q != '0);

   // Lap buffer bookkeeping: a write into a full buffer drops the oldest
   // entry unless a read retires it in the same cycle
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      lap_data_d  = lap_data_q;
      lap_valid_d = 1'b0;
      ovf_d       = ovf_q;
      if (i_clear) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         lap_data_d = '0;
         ovf_d      = 1'b0;
      end else begin
         if (lap_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (lap_rd) begin
            lap_data_d  = lap_mem_q[rd_ptr_q];
            lap_valid_d = 1'b1;
         end
         if (lap_rd || (lap_wr && full)) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (lap_wr && full && !lap_rd) begin
            ovf_d = 1'b1;
         end
         if (lap_wr && !full && !lap_rd) begin
            count_d = count_q + 1'b1;
         end else if (lap_rd && !lap_wr) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   // Lap buffer control registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         lap_data_q  <= '0;
         lap_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         lap_data_q  <= lap_data_d;
         lap_valid_q <= lap_valid_d;
         ovf_q       <= ovf_d;
      end
   end

   // Lap storage captures the time as it stood before this edge's tick
   always_ff @(posedge clk) begin
      if (lap_wr) begin
         lap_mem_q[wr_ptr_q] <= o_time;
      end
   end

   assign o_lap_data  = lap_data_q;
   assign o_lap_valid = lap_valid_q;
   assign o_lap_count = count_q;
   assign o_lap_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_lap_timer.sv
// ---------------------------------------------------------------------------
// tb_lap_timer
// Directed vector table plus hand sequences for lap_timer
// (CLK_FREQ_HZ=1000, TICK_HZ=100, LAP_DEPTH=4: one tick per 10 clocks).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lap_timer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_runstop = 1'b0;
   logic        i_clear = 1'b0;
   logic        i_lap = 1'b0;
   logic        i_lap_rd = 1'b0;
   logic        i_mode_down = 1'b0;
   logic        i_load = 1'b0;
   logic [23:0] i_preset = '0;
   logic [23:0] o_time;
   logic [23:0] o_lap_data;
   logic        o_lap_valid;
   logic [2:0]  o_lap_count;
   logic        o_lap_ovf;
   logic        o_running;
   logic        o_expired;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lap_timer #(
      .CLK_FREQ_HZ (1000),
      .TICK_HZ     (100),
      .LAP_DEPTH   (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_runstop   (i_runstop),
      .i_clear     (i_clear),
      .i_lap       (i_lap),
      .i_lap_rd    (i_lap_rd),
      .i_mode_down (i_mode_down),
      .i_load      (i_load),
      .i_preset    (i_preset),
      .o_time      (o_time),
      .o_lap_data  (o_lap_data),
      .o_lap_valid (o_lap_valid),
      .o_lap_count (o_lap_count),
      .o_lap_ovf   (o_lap_ovf),
      .o_running   (o_running),
      .o_expired   (o_expired)
   );

   typedef struct {
      int unsigned wait_n;
      logic        runstop;
      logic        clear;
      logic        lap;
      logic        rd;
      logic [23:0] e_time;
      logic        e_run;
      logic [2:0]  e_cnt;
      logic        e_valid;
      logic [23:0] e_data;
      logic        e_ovf;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs [NV];

   function automatic logic [23:0] pack(input int h, input int m, input int s, input int t);
      pack = {h[4:0], m[5:0], s[5:0], t[6:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance n rising edges, leaving the bench 1 time unit past the last
   task automatic cycles(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_clear();
      i_clear = 1'b1;
      cycles(1);
      i_clear = 1'b0;
   endtask

   task automatic do_runstop();
      i_runstop = 1'b1;
      cycles(1);
      i_runstop = 1'b0;
   endtask

   initial begin
      // wait, runstop, clear, lap, rd | time, running, count, valid, data, ovf
      vecs[0]  = '{0,   1'b0, 1'b0, 1'b0, 1'b0, 24'd0,   1'b0, 3'd0, 1'b0, 24'd0,  1'b0};
      vecs[1]  = '{0,   1'b1, 1'b0, 1'b0, 1'b0, 24'd0,   1'b1, 3'd0, 1'b0, 24'd0,  1'b0};
      vecs[2]  = '{999, 1'b0, 1'b0, 1'b0, 1'b0, 24'h80,  1'b1, 3'd0, 1'b0, 24'd0,  1'b0};
      vecs[3]  = '{0,   1'b1, 1'b0, 1'b0, 1'b0, 24'h80,  1'b0, 3'd0, 1'b0, 24'd0,  1'b0};
      vecs[4]  = '{49,  1'b0, 1'b0, 1'b0, 1'b0, 24'h80,  1'b0, 3'd0, 1'b0, 24'd0,  1'b0};
      vecs[5]  = '{0,   1'b0, 1'b1, 1'b0, 1'b0, 24'd0,   1'b0, 3'd0, 1'b0, 24'd0,  1'b0};
      vecs[6]  = '{0,   1'b1, 1'b0, 1'b0, 1'b0, 24'd0,   1'b1, 3'd0, 1'b0, 24'd0,  1'b0};
      vecs[7]  = '{104, 1'b0, 1'b0, 1'b1, 1'b0, 24'd10,  1'b1, 3'd1, 1'b0, 24'd0,  1'b0};
      vecs[8]  = '{99,  1'b0, 1'b0, 1'b1, 1'b0, 24'd20,  1'b1, 3'd2, 1'b0, 24'd0,  1'b0};
      vecs[9]  = '{99,  1'b0, 1'b0, 1'b1, 1'b0, 24'd30,  1'b1, 3'd3, 1'b0, 24'd0,  1'b0};
      vecs[10] = '{99,  1'b0, 1'b0, 1'b1, 1'b0, 24'd40,  1'b1, 3'd4, 1'b0, 24'd0,  1'b0};
      vecs[11] = '{99,  1'b0, 1'b0, 1'b1, 1'b0, 24'd50,  1'b1, 3'd4, 1'b0, 24'd0,  1'b1};
      vecs[12] = '{0,   1'b1, 1'b0, 1'b0, 1'b0, 24'd50,  1'b0, 3'd4, 1'b0, 24'd0,  1'b1};
      vecs[13] = '{0,   1'b0, 1'b0, 1'b0, 1'b1, 24'd50,  1'b0, 3'd3, 1'b1, 24'd20, 1'b1};
      vecs[14] = '{0,   1'b0, 1'b0, 1'b0, 1'b0, 24'd50,  1'b0, 3'd3, 1'b0, 24'd20, 1'b1};
      vecs[15] = '{0,   1'b0, 1'b0, 1'b0, 1'b1, 24'd50,  1'b0, 3'd2, 1'b1, 24'd30, 1'b1};
      vecs[16] = '{0,   1'b0, 1'b0, 1'b1, 1'b1, 24'd50,  1'b0, 3'd2, 1'b1, 24'd40, 1'b1};
      vecs[17] = '{0,   1'b0, 1'b0, 1'b0, 1'b0, 24'd50,  1'b0, 3'd2, 1'b0, 24'd40, 1'b1};
      vecs[18] = '{0,   1'b0, 1'b0, 1'b0, 1'b1, 24'd50,  1'b0, 3'd1, 1'b1, 24'd50, 1'b1};
      vecs[19] = '{0,   1'b0, 1'b0, 1'b0, 1'b1, 24'd50,  1'b0, 3'd0, 1'b1, 24'd50, 1'b1};
      vecs[20] = '{0,   1'b0, 1'b0, 1'b0, 1'b1, 24'd50,  1'b0, 3'd0, 1'b0, 24'd50, 1'b1};
      vecs[21] = '{0,   1'b0, 1'b0, 1'b1, 1'b1, 24'd50,  1'b0, 3'd1, 1'b0, 24'd50, 1'b1};
      vecs[22] = '{0,   1'b1, 1'b1, 1'b1, 1'b0, 24'd0,   1'b0, 3'd0, 1'b0, 24'd0,  1'b0};
      vecs[23] = '{0,   1'b0, 1'b0, 1'b1, 1'b0, 24'd0,   1'b0, 3'd0, 1'b0, 24'd0,  1'b0};
      vecs[24] = '{0,   1'b0, 1'b0, 1'b0, 1'b1, 24'd0,   1'b0, 3'd0, 1'b0, 24'd0,  1'b0};
      vecs[25] = '{0,   1'b1, 1'b0, 1'b0, 1'b0, 24'd0,   1'b1, 3'd0, 1'b0, 24'd0,  1'b0};
      vecs[26] = '{0,   1'b0, 1'b0, 1'b1, 1'b0, 24'd0,   1'b1, 3'd1, 1'b0, 24'd0,  1'b0};
      vecs[27] = '{13,  1'b0, 1'b0, 1'b0, 1'b1, 24'd1,   1'b1, 3'd0, 1'b1, 24'd0,  1'b0};

      // Reset state, sampled while reset is still held
      #12;
      check("rst time",    32'(o_time),      32'd0);
      check("rst running", 32'(o_running),   32'd0);
      check("rst count",   32'(o_lap_count), 32'd0);
      check("rst valid",   32'(o_lap_valid), 32'd0);
      check("rst expired", 32'(o_expired),   32'd0);
      #10;
      rst = 1'b1;
      cycles(1);

      for (int i = 0; i < NV; i++) begin
         cycles(vecs[i].wait_n);
         i_runstop = vecs[i].runstop;
         i_clear   = vecs[i].clear;
         i_lap     = vecs[i].lap;
         i_lap_rd  = vecs[i].rd;
         cycles(1);
         i_runstop = 1'b0;
         i_clear   = 1'b0;
         i_lap     = 1'b0;
         i_lap_rd  = 1'b0;
         check($sformatf("v%0d time", i),    32'(o_time),      32'(vecs[i].e_time));
         check($sformatf("v%0d running", i), 32'(o_running),   32'(vecs[i].e_run));
         check($sformatf("v%0d count", i),   32'(o_lap_count), 32'(vecs[i].e_cnt));
         check($sformatf("v%0d valid", i),   32'(o_lap_valid), 32'(vecs[i].e_valid));
         check($sformatf("v%0d data", i),    32'(o_lap_data),  32'(vecs[i].e_data));
         check($sformatf("v%0d ovf", i),     32'(o_lap_ovf),   32'(vecs[i].e_ovf));
         check($sformatf("v%0d expired", i), 32'(o_expired),   32'd0);
      end

      do_clear();

`ifdef LAP_TIMER_COUNTDOWN_EN
      // Saturating preset load
      i_preset = pack(31, 63, 63, 127);
      i_load   = 1'b1;
      cycles(1);
      i_load   = 1'b0;
      check("load saturate", 32'(o_time), 32'(pack(23, 59, 59, 99)));

      // Up-count wrap from the last instant of the day
      i_preset = pack(23, 59, 59, 99);
      i_load   = 1'b1;
      cycles(1);
      i_load   = 1'b0;
      check("load preset", 32'(o_time), 32'(pack(23, 59, 59, 99)));
      i_mode_down = 1'b0;
      do_runstop();
      cycles(9);
      check("wrap pre", 32'(o_time), 32'(pack(23, 59, 59, 99)));
      cycles(1);
      check("wrap time", 32'(o_time), 32'd0);
      check("wrap running", 32'(o_running), 32'd1);

      // Countdown to expiry
      do_clear();
      i_preset = pack(0, 0, 0, 3);
      i_load   = 1'b1;
      cycles(1);
      i_load   = 1'b0;
      i_mode_down = 1'b1;
      do_runstop();
      cycles(29);
      check("down pre time", 32'(o_time), 32'(pack(0, 0, 0, 1)));
      check("down pre expired", 32'(o_expired), 32'd0);
      cycles(1);
      check("down time", 32'(o_time), 32'd0);
      check("down expired", 32'(o_expired), 32'd1);
      check("down running", 32'(o_running), 32'd0);
      do_runstop();
      cycles(20);
      check("exp runstop expired", 32'(o_expired), 32'd1);
      check("exp runstop running", 32'(o_running), 32'd0);
      check("exp time held", 32'(o_time), 32'd0);
      i_lap = 1'b1;
      cycles(1);
      i_lap = 1'b0;
      check("exp lap ignored", 32'(o_lap_count), 32'd0);
      do_clear();
      check("exp clear expired", 32'(o_expired), 32'd0);
      check("exp clear running", 32'(o_running), 32'd0);
      i_mode_down = 1'b0;
      do_runstop();
      check("idle to run", 32'(o_running), 32'd1);
`else
      // Countdown controls are inert in this build
      i_preset = pack(23, 59, 59, 99);
      i_load   = 1'b1;
      cycles(1);
      i_load   = 1'b0;
      check("load ignored", 32'(o_time), 32'd0);
      i_mode_down = 1'b1;
      do_runstop();
      cycles(10);
      check("mode ignored time", 32'(o_time), 32'd1);
      check("mode ignored expired", 32'(o_expired), 32'd0);
      cycles(990);
      check("mode ignored sec", 32'(o_time), 32'h80);
      check("mode ignored running", 32'(o_running), 32'd1);
      i_mode_down = 1'b0;
`endif

      // Asynchronous reset in the middle of a run with a populated buffer
      do_clear();
      do_runstop();
      cycles(20);
      i_lap = 1'b1;
      cycles(5);
      i_lap = 1'b0;
      i_lap_rd = 1'b1;
      cycles(1);
      i_lap_rd = 1'b0;
      check("pre-rst time",  32'(o_time),      32'd2);
      check("pre-rst count", 32'(o_lap_count), 32'd3);
      check("pre-rst ovf",   32'(o_lap_ovf),   32'd1);
      check("pre-rst data",  32'(o_lap_data),  32'd2);
      check("pre-rst valid", 32'(o_lap_valid), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("async time",    32'(o_time),      32'd0);
      check("async running", 32'(o_running),   32'd0);
      check("async count",   32'(o_lap_count), 32'd0);
      check("async ovf",     32'(o_lap_ovf),   32'd0);
      check("async data",    32'(o_lap_data),  32'd0);
      check("async valid",   32'(o_lap_valid), 32'd0);
      check("async expired", 32'(o_expired),   32'd0);
      #3;
      rst = 1'b1;
      cycles(3);
      check("post-rst running", 32'(o_running), 32'd0);
      check("post-rst time",    32'(o_time),    32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lap_timer.md
LAP_TIMER -- requirements
Module: lap_timer

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, meaning sub-second resolution (centiseconds); legal range 2..100.
REQ-003 SHALL have parameter LAP_DEPTH, default 4, meaning lap buffer entries; power of two, 2..16.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_runstop  input  1  debounced single-cycle pulse; toggles run/stop.
REQ-007 SHALL have port i_clear  input  1  debounced pulse; clears time, laps and flags.
REQ-008 SHALL have port i_lap  input  1  debounced pulse; captures current time into lap buffer.
REQ-009 SHALL have port i_lap_rd  input  1  pulse; pops oldest lap.
REQ-010 SHALL have ports i_mode_down (1), i_load (1) and i_preset (24: hour[23:19], min[18:13], sec[12:7], tick[6:0]); all inputs.
REQ-011 SHALL have port o_time  output  24  live time, same field packing as i_preset.
REQ-012 SHALL have ports o_lap_data (24), o_lap_valid (1), o_lap_count ($clog2(LAP_DEPTH)+1), o_lap_ovf (1), o_running (1), o_expired (1); all outputs.

Function
REQ-013 SHALL implement FSM IDLE, RUN, STOP, EXPIRED: IDLE->RUN and STOP->RUN on i_runstop; RUN->STOP on i_runstop; any->IDLE on i_clear.
REQ-014 SHALL keep a prescaler counting 0..CLK_FREQ_HZ/TICK_HZ-1 only in RUN, held at 0 otherwise; tick asserted on terminal count.
REQ-015 SHALL, in up mode, advance tick 0..TICK_HZ-1, then sec 0..59, min 0..59, hour 0..23; 23:59:59:(TICK_HZ-1) wraps to all-zero.
REQ-016 SHALL update o_time on the same edge as the tick (zero additional latency); o_running=1 only in RUN.
REQ-017 SHALL give i_clear priority over all other same-cycle inputs.
REQ-018 SHALL, on i_lap in RUN or STOP, write the pre-tick o_time into a circular buffer; i_lap in IDLE or EXPIRED is ignored.
REQ-019 SHALL, when the buffer is full, overwrite the oldest entry on i_lap, keep o_lap_count=LAP_DEPTH, and set o_lap_ovf sticky until clear.
REQ-020 SHALL, on i_lap_rd with count>0, present the oldest entry on o_lap_data with o_lap_valid=1 for exactly one cycle on the following edge, and decrement count; i_lap_rd on empty is ignored.
REQ-021 SHALL, on same-cycle i_lap and i_lap_rd with count>0, perform both and leave count unchanged; with count=0, perform the write only.

Reset
REQ-022 SHALL, on rst low, asynchronously force IDLE, prescaler 0, o_time 0, buffer pointers 0, o_lap_count 0, o_lap_data 0, o_lap_valid 0, o_lap_ovf 0, o_running 0, o_expired 0.
REQ-023 SHALL make i_clear produce the same values as REQ-022 synchronously, except that i_mode_down is not stored.

Configuration
REQ-024 SHALL compile countdown support only when LAP_TIMER_COUNTDOWN_EN is defined.
REQ-025 With the macro defined, SHALL do the following:
- i_load in IDLE or STOP loads i_preset into o_time; out-of-range fields saturate to their maximum.
- i_mode_down=1 in RUN decrements per tick with borrow.
- On reaching all-zero, SHALL enter EXPIRED with o_expired=1 and o_time held at 0.
- i_runstop in EXPIRED is ignored.
REQ-026 Without the macro, SHALL keep all ports, ignore i_mode_down, i_load and i_preset, tie o_expired to 0, and never enter EXPIRED.

Structure
REQ-027 SHALL place field widths, field bit positions, max constants (59, 23) and the FSM state enum in shared package timer_pkg.
REQ-028 SHALL implement the prescaler and cascaded counter as sub-module time_counter; the FSM and lap buffer stay in lap_timer.

Verification (CLK_FREQ_HZ=1000, TICK_HZ=100, LAP_DEPTH=4)
REQ-029 SHALL check: runstop, then 1000 clk -> o_time = 0:0:1:00; runstop again -> o_time frozen and o_running=0.
REQ-030 SHALL check: preset to 23:59:59:99 via load (macro on), up mode, run, 10 clk -> o_time = 0.
REQ-031 SHALL check: 5 laps at 0.10 s spacing -> count=4, ovf=1; first rd returns 0:0:0:20.
REQ-032 SHALL check: lap and rd in the same cycle at count=2 -> count stays 2, lap_valid pulses for 1 cycle.
REQ-033 SHALL check: load 0:0:0:03, down mode, run, 30 clk -> o_time=0, o_expired=1; runstop is ignored; clear -> IDLE.
REQ-034 SHALL check: rst low mid-RUN -> all outputs 0 immediately, with no clock edge required.
